// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-port priority, same-cycle bypass
// and a per-register busy scoreboard so issue can stall on pending producers.
module regfile_mp #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rready_o,
  input  logic [NWR-1:0]      wen_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic                alloc_en_i,
  input  logic [AW-1:0]       alloc_addr_i,
  output logic [NREGS-1:0]    busy_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Allocation is applied after retirement so a new producer keeps the register busy.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wen_i[j]) begin
        busy_next[waddr_i[j*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en_i) begin
      busy_next[alloc_addr_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Ascending port order lets the highest-index writer land last and win.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wen_i[j] && (waddr_i[j*AW +: AW] != '0)) begin
          regs[waddr_i[j*AW +: AW]] <= wdata_i[j*XLEN +: XLEN];
        end
      end
      busy <= busy_next;
    end
  end

  assign busy_o = busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            hit;

    assign ra = raddr_i[i*AW +: AW];

    always_comb begin
      data = regs[ra];
      hit  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wen_i[j] && (waddr_i[j*AW +: AW] == ra)) begin
          data = wdata_i[j*XLEN +: XLEN];
          hit  = 1'b1;
        end
      end
    end

    always_comb begin
      rdata_o[i*XLEN +: XLEN] = '0;
      rready_o[i]             = 1'b0;
      if (rst) begin
        if (ra == '0) begin
          rready_o[i] = 1'b1;
        end else begin
          rdata_o[i*XLEN +: XLEN] = data;
          rready_o[i]             = hit || !busy[ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   raddr_i;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]      rready_o;
  logic [NWR-1:0]      wen_i;
  logic [NWR*AW-1:0]   waddr_i;
  logic [NWR*XLEN-1:0] wdata_i;
  logic                alloc_en_i;
  logic [AW-1:0]       alloc_addr_i;
  logic [NREGS-1:0]    busy_o;

  logic [XLEN-1:0]  mreg [NREGS];
  logic [NREGS-1:0] mbusy;
  bit               modelValid = 0;
  int               total = 0;
  int               bad = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .raddr_i(raddr_i), .rdata_o(rdata_o), .rready_o(rready_o),
    .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .alloc_en_i(alloc_en_i),
    .alloc_addr_i(alloc_addr_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                               input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                               input logic [XLEN-1:0] wd0, input logic [XLEN-1:0] wd1,
                               input logic ae, input logic [AW-1:0] aa);
    rst          = r;
    raddr_i      = {ra1, ra0};
    wen_i        = we;
    waddr_i      = {wa1, wa0};
    wdata_i      = {wd1, wd0};
    alloc_en_i   = ae;
    alloc_addr_i = aa;
  endtask

  // Reference read: the last enabled writer to this address wins, else the array.
  function automatic logic [XLEN-1:0] expData(input int p);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = raddr_i[p*AW +: AW];
    if (!rst || a == 0) return '0;
    v = mreg[a];
    for (int j = 0; j < NWR; j++)
      if (wen_i[j] && waddr_i[j*AW +: AW] == a) v = wdata_i[j*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic expReady(input int p);
    logic [AW-1:0] a;
    a = raddr_i[p*AW +: AW];
    if (!rst) return 1'b0;
    if (a == 0) return 1'b1;
    for (int j = 0; j < NWR; j++)
      if (wen_i[j] && waddr_i[j*AW +: AW] == a) return 1'b1;
    return !mbusy[a];
  endfunction

  task automatic settle();
    #1;
    for (int p = 0; p < NRD; p++) begin
      checkOutput($sformatf("rdata%0d", p), rdata_o[p*XLEN +: XLEN], expData(p));
      checkOutput($sformatf("rready%0d", p), {63'b0, rready_o[p]}, {63'b0, expReady(p)});
    end
    if (modelValid) checkOutput("busy", {32'b0, busy_o}, {32'b0, mbusy});
  endtask

  task automatic advance();
    logic [NREGS-1:0] nb;
    @(posedge clk);
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) mreg[r] = '0;
      mbusy      = '0;
      modelValid = 1;
    end else begin
      nb = mbusy;
      for (int j = 0; j < NWR; j++) begin
        if (wen_i[j]) begin
          if (waddr_i[j*AW +: AW] != 0) mreg[waddr_i[j*AW +: AW]] = wdata_i[j*XLEN +: XLEN];
          nb[waddr_i[j*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en_i) nb[alloc_addr_i] = 1'b1;
      nb[0] = 1'b0;
      mbusy = nb;
    end
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    settle(); advance();
    applyStimulus(0, 5, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    settle(); advance();

    // Reset after a write discards the stored value
    applyStimulus(1, 5, 0, 2'b01, 5, 0, 64'h1234, 0, 1, 6);
    settle(); advance();
    applyStimulus(0, 5, 5, 2'b01, 5, 0, 64'h9999, 0, 1, 5);
    settle();
    checkOutput("rst_rdata", rdata_o[63:0], 64'h0);
    checkOutput("rst_rready", {62'b0, rready_o}, 64'h0);
    advance();
    applyStimulus(1, 5, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("rst_x5", rdata_o[63:0], 64'h0);
    checkOutput("rst_busy", {32'b0, busy_o}, 64'h0);
    advance();

    // x0 ignores writes and allocs
    applyStimulus(1, 0, 0, 2'b01, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
    settle();
    checkOutput("x0_rdata", rdata_o[63:0], 64'h0);
    checkOutput("x0_rready", {63'b0, rready_o[0]}, 64'h1);
    advance();
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("x0_busy", {63'b0, busy_o[0]}, 64'h0);
    checkOutput("x0_rdata2", rdata_o[63:0], 64'h0);
    advance();

    // Bypass and persistence
    applyStimulus(1, 0, 7, 2'b01, 7, 0, 64'hDEAD_BEEF, 0, 0, 0);
    settle();
    checkOutput("byp_x7", rdata_o[127:64], 64'hDEAD_BEEF);
    advance();
    applyStimulus(1, 0, 7, 2'b00, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("stored_x7", rdata_o[127:64], 64'hDEAD_BEEF);
    advance();

    // Highest-index write port wins
    applyStimulus(1, 3, 0, 2'b11, 3, 3, 64'h11, 64'h22, 0, 0);
    settle();
    checkOutput("prio_byp", rdata_o[63:0], 64'h22);
    advance();
    applyStimulus(1, 3, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("prio_stored", rdata_o[63:0], 64'h22);
    advance();

    // Scoreboard set and clear
    applyStimulus(1, 9, 0, 2'b00, 0, 0, 0, 0, 1, 9);
    settle();
    checkOutput("alloc_same_cycle", {63'b0, rready_o[0]}, 64'h1);
    advance();
    applyStimulus(1, 9, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("busy9_set", {63'b0, busy_o[9]}, 64'h1);
    checkOutput("x9_notready", {63'b0, rready_o[0]}, 64'h0);
    advance();
    applyStimulus(1, 9, 0, 2'b01, 9, 0, 64'h55, 0, 0, 0);
    settle();
    checkOutput("x9_byp_ready", {63'b0, rready_o[0]}, 64'h1);
    checkOutput("x9_byp_data", rdata_o[63:0], 64'h55);
    advance();
    applyStimulus(1, 9, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("busy9_clr", {63'b0, busy_o[9]}, 64'h0);
    advance();

    // Set wins over clear
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 4);
    settle(); advance();
    applyStimulus(1, 0, 0, 2'b10, 0, 4, 0, 64'h77, 1, 4);
    settle(); advance();
    applyStimulus(1, 4, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("soc_busy4", {63'b0, busy_o[4]}, 64'h1);
    checkOutput("soc_notready", {63'b0, rready_o[0]}, 64'h0);
    checkOutput("soc_stored", rdata_o[63:0], 64'h77);
    advance();

    // Randomized traffic on a narrow address range to provoke conflicts
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] ra0, ra1, wa0, wa1, aa;
      ra0 = AW'($urandom_range(0, 7));
      ra1 = AW'($urandom_range(0, 7));
      wa0 = AW'($urandom_range(0, 7));
      wa1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      aa  = AW'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 39) != 0, ra0, ra1, 2'($urandom), wa0, wa1,
                    {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2) == 0, aa);
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
